// File: rtl/max_pool_x_sched_pkg.sv
// rtl/max_pool_x_sched_pkg.sv - shared types for the event-graph pipeline and the max_pool_x scheduler
package aegnn;

  localparam int F_WIDTH = 8;

  typedef logic [5:0] x_idx_t;
  typedef logic [5:0] y_idx_t;
  typedef logic [7:0] grid_idx_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAN = 3'd1,
    GAP   = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    OUT   = 3'd5
  } mp_sched_state_e;

endpackage

// File: rtl/max_pool_x_sched_wdog.sv
// rtl/max_pool_x_sched_wdog.sv - saturating 16-bit clear/count/expire counter
module max_pool_x_sched_wdog (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_cnt_en,
  input  logic [15:0] i_limit,
  output logic        o_expire
);

  logic [15:0] r_cnt;
  logic [15:0] w_cnt_inc;

  // Expire flags the counting cycle whose incremented value reaches the limit,
  // so a limit of N ends the window after exactly N counting cycles.
  always_comb begin
    w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    o_expire  = i_cnt_en && (w_cnt_inc >= i_limit);
  end

  // Counter register: clear wins over count, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= 16'd0;
    end else if (i_cnt_en) begin
      r_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/max_pool_x_sched.sv
// rtl/max_pool_x_sched.sv - start/clean/result sequencing around max_pool_x
module max_pool_x_sched
  import aegnn::*;
#(
  parameter int L4_OUT_C  = 32,
  parameter int CLEAN_GAP = 1,
  parameter int TIMEOUT   = 1023
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  x_idx_t                              in_x,
  input  y_idx_t                              in_y,
  input  logic [L4_OUT_C-1:0][F_WIDTH-1:0]    in_feat_pack,
  input  logic                                clean_req,
  output logic                                mp_start,
  output logic                                mp_clean,
  output x_idx_t                              mp_event_x,
  output y_idx_t                              mp_event_y,
  output logic [L4_OUT_C-1:0][F_WIDTH-1:0]    mp_feat_pack,
  input  logic                                mp_done,
  input  grid_idx_t                           mp_grid_idx,
  output logic                                out_valid,
  input  logic                                out_ready,
  output grid_idx_t                           out_grid_idx,
  output logic                                busy,
  output logic                                timeout_err,
  output logic [15:0]                         evt_cnt
);

  mp_sched_state_e r_state;
  mp_sched_state_e w_state_next;
  logic            r_clean_pend;
  logic            w_clean_any;
  logic            w_accept;
  logic            w_done;
  logic            w_tmo;
  logic            w_enter_clean;
  logic            w_wd_clr;
  logic            w_wd_en;
  logic [15:0]     w_wd_limit;
  logic            w_wd_expire;

  // A request seen in the same IDLE cycle as an event already blocks the
  // accept, so a clean is never overtaken by an event that arrives with it.
  assign w_clean_any = r_clean_pend || clean_req;
  assign in_ready    = (r_state == IDLE) && !w_clean_any && !rst;
  assign w_accept    = in_valid && in_ready;

  assign mp_start  = (r_state == START);
  assign mp_clean  = (r_state == CLEAN);
  assign out_valid = (r_state == OUT);
  assign busy      = (r_state != IDLE);

  // One counter serves both the post-clean gap and the WAIT watchdog.
  assign w_wd_clr   = (r_state == START) || (r_state == CLEAN);
  assign w_wd_en    = (r_state == WAIT) || (r_state == GAP);
  assign w_wd_limit = (r_state == GAP) ? 16'(CLEAN_GAP) : 16'(TIMEOUT);

  max_pool_x_sched_wdog u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_wd_clr),
    .i_cnt_en (w_wd_en),
    .i_limit  (w_wd_limit),
    .o_expire (w_wd_expire)
  );

  // Next-state decode; done beats the watchdog when both land together.
  always_comb begin
    w_state_next  = r_state;
    w_done        = 1'b0;
    w_tmo         = 1'b0;
    w_enter_clean = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_clean_any) begin
          w_state_next  = CLEAN;
          w_enter_clean = 1'b1;
        end else if (w_accept) begin
          w_state_next = START;
        end
      end
      CLEAN: w_state_next = (CLEAN_GAP == 0) ? IDLE : GAP;
      GAP: begin
        if (w_wd_expire) w_state_next = IDLE;
      end
      START: w_state_next = WAIT;
      WAIT: begin
        if (mp_done) begin
          w_state_next = OUT;
          w_done       = 1'b1;
        end else if (w_wd_expire) begin
          w_state_next = IDLE;
          w_tmo        = 1'b1;
        end
      end
      OUT: begin
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, pending-clean flag, status and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_clean_pend <= 1'b0;
      out_grid_idx <= '0;
      evt_cnt      <= 16'd0;
      timeout_err  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_enter_clean) begin
        r_clean_pend <= 1'b0;
      end else if (clean_req) begin
        r_clean_pend <= 1'b1;
      end
      if (w_done) begin
        out_grid_idx <= mp_grid_idx;
        evt_cnt      <= evt_cnt + 16'd1;
      end
      if (w_tmo) timeout_err <= 1'b1;
    end
  end

  // Event registers move only on an accepted input, keeping max_pool_x inputs frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      mp_event_x   <= '0;
      mp_event_y   <= '0;
      mp_feat_pack <= '0;
    end else if (w_accept) begin
      mp_event_x   <= in_x;
      mp_event_y   <= in_y;
      mp_feat_pack <= in_feat_pack;
    end
  end

endmodule

// File: tb/tb_max_pool_x_sched.sv
// tb/tb_max_pool_x_sched.sv - directed self-checking bench for max_pool_x_sched
module tb_max_pool_x_sched;
  import aegnn::*;

  localparam int NC = 32;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        in_valid;
  logic                        in_ready;
  x_idx_t                      in_x;
  y_idx_t                      in_y;
  logic [NC-1:0][F_WIDTH-1:0]  in_feat_pack;
  logic                        clean_req;
  logic                        mp_start;
  logic                        mp_clean;
  x_idx_t                      mp_event_x;
  y_idx_t                      mp_event_y;
  logic [NC-1:0][F_WIDTH-1:0]  mp_feat_pack;
  logic                        mp_done;
  grid_idx_t                   mp_grid_idx;
  logic                        out_valid;
  logic                        out_ready;
  grid_idx_t                   out_grid_idx;
  logic                        busy;
  logic                        timeout_err;
  logic [15:0]                 evt_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_clean = 0;
  int clean_snap;

  logic [NC-1:0][F_WIDTH-1:0] feat_a, feat_b, feat_c;

  max_pool_x_sched #(.L4_OUT_C(NC), .CLEAN_GAP(1), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_feat_pack (in_feat_pack),
    .clean_req    (clean_req),
    .mp_start     (mp_start),
    .mp_clean     (mp_clean),
    .mp_event_x   (mp_event_x),
    .mp_event_y   (mp_event_y),
    .mp_feat_pack (mp_feat_pack),
    .mp_done      (mp_done),
    .mp_grid_idx  (mp_grid_idx),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_grid_idx (out_grid_idx),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .evt_cnt      (evt_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mp_clean) n_clean <= n_clean + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      feat_a[i] = F_WIDTH'(i + 1);
      feat_b[i] = (i == NC - 1) ? F_WIDTH'(1) : F_WIDTH'(i + 2);
      feat_c[i] = F_WIDTH'(i);
    end
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_feat_pack = '0;
    clean_req = 1'b0; mp_done = 1'b0; mp_grid_idx = '0; out_ready = 1'b0;

    // Reset state
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mp_start", mp_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_evt_cnt", evt_cnt, 0);
    chk("rst_mp_x", mp_event_x, 0);
    rst = 1'b0;
    settle();
    chk("post_rst_in_ready", in_ready, 1);

    // Event 1: accept at T, start at T+1, done 5 cycles after start
    in_valid = 1'b1; in_x = 6'd16; in_y = 6'd16; in_feat_pack = feat_a;
    step();
    in_valid = 1'b0; in_feat_pack = '0;
    chk("e1_start", mp_start, 1);
    chk("e1_x", mp_event_x, 16);
    chk("e1_y", mp_event_y, 16);
    chk("e1_feat", mp_feat_pack, feat_a);
    step();
    chk("e1_start_single", mp_start, 0);
    chk("e1_busy", busy, 1);
    step(); step(); step(); step();
    chk("e1_wait_no_out", out_valid, 0);
    mp_done = 1'b1; mp_grid_idx = 8'h55;
    step();
    mp_done = 1'b0; mp_grid_idx = 8'h00;
    chk("e1_out_valid", out_valid, 1);
    chk("e1_grid", out_grid_idx, 8'h55);
    chk("e1_evt_cnt", evt_cnt, 1);
    chk("e1_in_ready_out", in_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("e1_in_ready_after", in_ready, 1);
    chk("e1_out_dropped", out_valid, 0);

    // Event 2: downstream stalls 4 cycles
    in_valid = 1'b1; in_feat_pack = feat_b;
    step();
    in_valid = 1'b0; in_feat_pack = '0;
    chk("e2_start", mp_start, 1);
    step(); step();
    mp_done = 1'b1; mp_grid_idx = 8'h2a;
    step();
    mp_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("e2_hold_valid", out_valid, 1);
      chk("e2_hold_feat", mp_feat_pack, feat_b);
      chk("e2_hold_grid", out_grid_idx, 8'h2a);
      chk("e2_hold_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    settle();
    chk("e2_valid_at_hs", out_valid, 1);
    step();
    out_ready = 1'b0;
    chk("e2_in_ready_after", in_ready, 1);
    chk("e2_evt_cnt", evt_cnt, 2);

    // Clean and event in the same IDLE cycle: clean first
    clean_req = 1'b1; in_valid = 1'b1; in_x = 6'd1; in_y = 6'd1; in_feat_pack = feat_c;
    settle();
    chk("c1_blocks_accept", in_ready, 0);
    step();
    clean_req = 1'b0;
    chk("c1_clean", mp_clean, 1);
    chk("c1_no_start", mp_start, 0);
    chk("c1_x_frozen", mp_event_x, 16);
    step();
    chk("c1_gap_clean_low", mp_clean, 0);
    chk("c1_gap_in_ready", in_ready, 0);
    step();
    chk("c1_ready_again", in_ready, 1);
    step();
    in_valid = 1'b0; in_feat_pack = '0;
    chk("c1_start", mp_start, 1);
    chk("c1_x", mp_event_x, 1);
    chk("c1_feat", mp_feat_pack, feat_c);

    // Clean request during WAIT is deferred past the OUT handshake
    step();
    clean_snap = n_clean;
    clean_req = 1'b1;
    step();
    clean_req = 1'b0;
    chk("c2_wait_no_clean", mp_clean, 0);
    mp_done = 1'b1; mp_grid_idx = 8'h11;
    step();
    mp_done = 1'b0;
    chk("c2_out_valid", out_valid, 1);
    chk("c2_out_no_clean", mp_clean, 0);
    chk("c2_evt_cnt", evt_cnt, 3);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("c2_idle_pending", in_ready, 0);
    chk("c2_idle_no_clean", mp_clean, 0);
    step();
    chk("c2_clean", mp_clean, 1);
    step(); step(); step(); step();
    chk("c2_one_clean", n_clean - clean_snap, 1);
    chk("c2_ready", in_ready, 1);

    // Watchdog: no done for 8 WAIT cycles
    in_valid = 1'b1; in_x = 6'd3; in_y = 6'd4; in_feat_pack = feat_a;
    step();
    in_valid = 1'b0;
    chk("t_start", mp_start, 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t_wait_busy", busy, 1);
      chk("t_wait_no_out", out_valid, 0);
      chk("t_wait_no_err", timeout_err, 0);
    end
    step();
    chk("t_err", timeout_err, 1);
    chk("t_idle", busy, 0);
    chk("t_no_out", out_valid, 0);
    chk("t_evt_cnt", evt_cnt, 3);
    mp_done = 1'b1;
    step();
    mp_done = 1'b0;
    chk("t_done_ignored_idle", out_valid, 0);
    chk("t_err_sticky", timeout_err, 1);

    // Reset in WAIT with a clean pending
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    clean_req = 1'b1;
    step();
    clean_req = 1'b0;
    chk("r_in_wait", busy, 1);
    rst = 1'b1;
    step();
    chk("r_busy", busy, 0);
    chk("r_start", mp_start, 0);
    chk("r_clean", mp_clean, 0);
    chk("r_out_valid", out_valid, 0);
    chk("r_in_ready", in_ready, 0);
    chk("r_evt_cnt", evt_cnt, 0);
    chk("r_err", timeout_err, 0);
    chk("r_mp_x", mp_event_x, 0);
    chk("r_feat", mp_feat_pack, 0);
    chk("r_grid", out_grid_idx, 0);
    rst = 1'b0;
    clean_snap = n_clean;
    step(); step(); step(); step();
    chk("r_no_clean_after", n_clean - clean_snap, 0);
    chk("r_ready_after", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
